vx_tensor_commit_rx: RTL and testbench
======================================

# vx_tensor_commit_rx

Commit-side receiver for the tensor core's paired-subcommit protocol. The tensor core retires every HMMA uop as two back-to-back commit beats: the first carries the `wb_data_0` register half and the second the `wb_data_1` half, both tagged with the same `rd`. This block sits between the tensor core's `commit_if` master and the issue slot's commit arbiter. It re-tags the second beat to `rd+1`, rewrites `sop`/`eop` so the pair retires as one two-beat transaction, counts completed uops, and registers the output through a 2-entry skid buffer.

## Interface
- `CNT_W`, 32: width of completed-uop counter.
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-low reset.
- `in_if`  VX_commit_if.slave  –: subcommit beats from tensor core; fields uuid, wid, tmask, PC, wb, rd, data[`NUM_THREADS`][`XLEN`], pid, sop, eop.
- `out_if`  VX_commit_if.master  –: re-tagged beats to commit arbiter; same field set.
- `uop_count`  out  CNT_W: number of completed pairs.
- `pair_err`  out  1: sticky protocol error (only when the check feature is compiled in).

## Operation
- FSM, 2 states: HALF0 (expect first beat) and HALF1 (expect second beat). Reset state is HALF0.
- HALF0, `in` fire:
  - Capture uuid, wid, rd into pair registers.
  - Forward the beat unchanged except sop=1, eop=0.
  - Next state HALF1.
- HALF1, `in` fire:
  - Forward the beat with rd = captured rd + 1, computed modulo 2^`NR_BITS`.
  - sop=0, eop=1.
  - `uop_count` += 1, wrapping at 2^CNT_W.
  - Next state HALF0.
- Input sop/eop values are ignored. pid is passed through. tmask, PC, wb and data are passed through per beat.
- `in_if.ready` = skid buffer not full. `out_if.valid` = skid buffer not empty.
- No beat is dropped, duplicated or reordered.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is presented on `out_if` from cycle N+1.
- Throughput is 1 beat/cycle while `out_if.ready`=1.
- `in_if.ready` is a registered function of buffer occupancy only. It has no combinational path from `out_if.ready`.
- `out_if` data holds stable while valid && !ready.
- Simultaneous push and pop on a full buffer is not possible, because ready is low. With 1 entry held, push and pop in the same cycle keep occupancy at 1.
- Buffer full (2 entries): `in_if.ready`=0 until a pop. The FSM state does not change without an `in` fire.
- Reset values: `out_if.valid`=0, `in_if.ready`=1, `uop_count`=0, `pair_err`=0, FSM=HALF0, buffer empty.
- Reset asserted mid-pair discards any half pair and any buffered beats. There is no partial recovery.

## Configuration
- `TENSOR_COMMIT_CHECK_EN` defined:
  - In HALF1, if the beat's uuid or wid differs from the captured value, set `pair_err`. The beat is still forwarded.
  - Captured rd == 2^`NR_BITS`−1 also sets `pair_err` (rd+1 wraps).
  - `pair_err` is sticky until reset.
- Not defined: no compare logic. `pair_err` is tied 0.

## Structure
- Shared package (`VX_gpu_pkg`):
  - Typedef `tensor_commit_half_e` {HALF0, HALF1}.
  - Typedef for the commit beat struct, used by the skid buffer payload.
- One sub-module, `vx_tensor_commit_skid`: a 2-entry valid/ready skid buffer, parameterised by payload width, with asynchronous active-low reset.
- The FSM, pair registers, counter and checker live in the top module.

## Test plan
- Single uop, rd=5, uuid=0x10, out ready always: two out beats on consecutive cycles, rd 5 then 6, sop/eop 1/0 then 0/1, data equal to inputs, `uop_count`=1.
- 8 uops streamed back-to-back, out ready=1: 16 out beats with no bubbles, `in_if.ready` never low, `uop_count`=8.
- Same 8 uops with out ready toggling 1,0,0,1: `in_if.ready` falls only at occupancy 2, no beat lost or reordered, output data stable across stalls.
- Check enabled, second beat uuid=0x11 after first 0x10: `pair_err`=1 from the next cycle and stays 1, both beats forwarded. With the macro undefined, `pair_err` stays 0.
- Check enabled, rd=2^`NR_BITS`−1: second beat rd=0 and `pair_err`=1.
- Reset asserted after the first beat of a pair: outputs return to reset values asynchronously, and a new pair with rd=3 produces rd 3, 4 with sop=1 on the first beat.

Source files
------------

// File: rtl/VX_gpu_pkg.sv
// Shared GPU types: commit beat layout and the tensor commit pairing FSM states.
package VX_gpu_pkg;

    localparam int unsigned NUM_THREADS = 4;
    localparam int unsigned XLEN        = 32;
    localparam int unsigned NR_BITS     = 6;
    localparam int unsigned NW_BITS     = 2;
    localparam int unsigned UUID_WIDTH  = 16;
    localparam int unsigned PID_WIDTH   = 1;

    typedef enum logic {
        HALF0,
        HALF1
    } tensor_commit_half_e;

    typedef struct packed {
        logic [UUID_WIDTH-1:0]              uuid;
        logic [NW_BITS-1:0]                 wid;
        logic [NUM_THREADS-1:0]             tmask;
        logic [XLEN-1:0]                    PC;
        logic                               wb;
        logic [NR_BITS-1:0]                 rd;
        logic [NUM_THREADS-1:0][XLEN-1:0]   data;
        logic [PID_WIDTH-1:0]               pid;
        logic                               sop;
        logic                               eop;
    } tensor_commit_beat_t;

endpackage

// File: rtl/VX_commit_if.sv
// Valid/ready commit channel carrying one commit beat per transfer.
interface VX_commit_if;
    import VX_gpu_pkg::*;

    logic                valid;
    tensor_commit_beat_t data;
    logic                ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/vx_tensor_commit_skid.sv
// Two-entry valid/ready skid buffer; in_ready depends only on registered occupancy.
module vx_tensor_commit_skid #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push;
    logic             pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/vx_tensor_commit_rx.sv
// Pairs tensor-core subcommit beats into one two-beat commit (rd, rd+1) and counts uops.
// Optional pairing checker enabled by defining TENSOR_COMMIT_CHECK_EN.
module vx_tensor_commit_rx
    import VX_gpu_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    VX_commit_if.slave       in_if,
    VX_commit_if.master      out_if,
    output logic [CNT_W-1:0] uop_count,
    output logic             pair_err
);

    localparam int unsigned BEAT_W = $bits(tensor_commit_beat_t);

    tensor_commit_half_e state_q, state_d;
    logic [NR_BITS-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    tensor_commit_beat_t beat;
    logic                in_fire;
    logic                skid_in_ready;
    logic [BEAT_W-1:0]   skid_out_data;

    assign in_if.ready = skid_in_ready;
    assign in_fire     = in_if.valid && skid_in_ready;
    assign uop_count   = cnt_q;

    always_comb begin
        beat    = in_if.data;
        state_d = state_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            HALF0: begin
                beat.sop = 1'b1;
                beat.eop = 1'b0;
                if (in_fire) begin
                    state_d = HALF1;
                    rd_d    = in_if.data.rd;
                end
            end
            HALF1: begin
                beat.rd  = rd_q + NR_BITS'(1);
                beat.sop = 1'b0;
                beat.eop = 1'b1;
                if (in_fire) begin
                    state_d = HALF0;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HALF0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef TENSOR_COMMIT_CHECK_EN
    logic [UUID_WIDTH-1:0] uuid_q;
    logic [NW_BITS-1:0]    wid_q;
    logic                  pair_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uuid_q     <= '0;
            wid_q      <= '0;
            pair_err_q <= 1'b0;
        end else if (in_fire) begin
            if (state_q == HALF0) begin
                uuid_q <= in_if.data.uuid;
                wid_q  <= in_if.data.wid;
            end else if ((in_if.data.uuid != uuid_q) || (in_if.data.wid != wid_q)
                         || (rd_q == '1)) begin
                // Sticky: a bad pair is still forwarded, only flagged.
                pair_err_q <= 1'b1;
            end
        end
    end

    assign pair_err = pair_err_q;
`else
    assign pair_err = 1'b0;
`endif

    vx_tensor_commit_skid #(
        .WIDTH (BEAT_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_if.valid),
        .in_ready  (skid_in_ready),
        .in_data   (beat),
        .out_valid (out_if.valid),
        .out_ready (out_if.ready),
        .out_data  (skid_out_data)
    );

    assign out_if.data = tensor_commit_beat_t'(skid_out_data);

endmodule

// File: tb/tb_vx_tensor_commit_rx.sv
// Self-checking bench for vx_tensor_commit_rx against a queue-based pairing model.
module tb_vx_tensor_commit_rx;
    import VX_gpu_pkg::*;

`ifdef TENSOR_COMMIT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] uop_count;
    logic        pair_err;

    VX_commit_if in_if ();
    VX_commit_if out_if ();

    vx_tensor_commit_rx #(
        .CNT_W (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_if     (in_if),
        .out_if    (out_if),
        .uop_count (uop_count),
        .pair_err  (pair_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: expected output beats in order, plus pairing state.
    tensor_commit_beat_t exp_q [$];
    tensor_commit_beat_t stim_q [$];
    tensor_commit_beat_t saved_q [$];
    tensor_commit_beat_t outs [$];
    int                  out_cyc [$];
    bit                  phase;
    int unsigned         first_rd;
    logic [UUID_WIDTH-1:0] first_uuid;
    logic [NW_BITS-1:0]  first_wid;
    int unsigned         uop_model;
    bit                  err_model;
    bit                  held_v;
    tensor_commit_beat_t held;
    bit                  ready_low_seen;
    bit                  done;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic tensor_commit_beat_t mk_beat(input int unsigned uuid, input int unsigned wid,
                                                    input int unsigned rd);
        tensor_commit_beat_t b;
        b.uuid  = UUID_WIDTH'(uuid);
        b.wid   = NW_BITS'(wid);
        b.tmask = NUM_THREADS'($urandom);
        b.PC    = $urandom;
        b.wb    = 1'($urandom);
        b.rd    = NR_BITS'(rd);
        for (int t = 0; t < NUM_THREADS; t++) b.data[t] = $urandom;
        b.pid   = PID_WIDTH'($urandom);
        b.sop   = 1'($urandom);
        b.eop   = 1'($urandom);
        return b;
    endfunction

    task automatic model_accept(input tensor_commit_beat_t b);
        tensor_commit_beat_t e;
        e = b;
        if (!phase) begin
            e.sop      = 1'b1;
            e.eop      = 1'b0;
            first_rd   = int'(b.rd);
            first_uuid = b.uuid;
            first_wid  = b.wid;
        end else begin
            e.rd  = NR_BITS'((first_rd + 1) % (1 << NR_BITS));
            e.sop = 1'b0;
            e.eop = 1'b1;
            uop_model++;
            if (b.uuid != first_uuid || b.wid != first_wid || first_rd == (1 << NR_BITS) - 1)
                err_model = 1'b1;
        end
        phase = ~phase;
        exp_q.push_back(e);
    endtask

    task automatic model_clear();
        exp_q.delete();
        phase     = 1'b0;
        uop_model = 0;
        err_model = 1'b0;
        held_v    = 1'b0;
    endtask

    // One clock: check DUT state against model, then record this cycle's handshakes.
    task automatic cycle(output bit in_fire);
        bit out_fire;
        @(negedge clk);
        cyc++;
        chk("in_ready", 256'(in_if.ready), 256'(exp_q.size() != 2));
        chk("out_valid", 256'(out_if.valid), 256'(exp_q.size() != 0));
        chk("uop_count", 256'(uop_count), 256'(uop_model));
        chk("pair_err", 256'(pair_err), 256'(CHK ? err_model : 1'b0));
        if (held_v) chk("stall_hold", 256'(out_if.data), 256'(held));
        if (!in_if.ready) ready_low_seen = 1'b1;
        in_fire  = in_if.valid && in_if.ready;
        out_fire = out_if.valid && out_if.ready;
        held_v   = out_if.valid && !out_if.ready;
        held     = out_if.data;
        if (out_fire && exp_q.size() != 0) begin
            chk("beat", 256'(out_if.data), 256'(exp_q[0]));
            void'(exp_q.pop_front());
            outs.push_back(out_if.data);
            out_cyc.push_back(cyc);
        end
        if (in_fire) model_accept(in_if.data);
        @(posedge clk);
        #1;
    endtask

    // Push stim_q through the DUT; mode 1 toggles out ready 1,0,0,1.
    task automatic run(input int mode, input int budget);
        int idx;
        bit fired;
        idx  = 0;
        done = 1'b0;
        outs.delete();
        out_cyc.delete();
        for (int c = 0; c < budget; c++) begin
            in_if.valid  = (idx < stim_q.size());
            if (idx < stim_q.size()) in_if.data = stim_q[idx];
            out_if.ready = (mode == 0) ? 1'b1 : ((c % 4) == 0 || (c % 4) == 3);
            cycle(fired);
            if (fired) idx++;
            if (idx == stim_q.size() && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        chk("no_timeout", 256'(done), 256'(1));
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic add_pairs(input int n);
        int unsigned u, w, r;
        for (int i = 0; i < n; i++) begin
            u = $urandom;
            w = $urandom;
            r = $urandom_range(0, (1 << NR_BITS) - 2);
            stim_q.push_back(mk_beat(u, w, r));
            stim_q.push_back(mk_beat(u, w, r));
        end
    endtask

    initial begin
        bit f;
        reset        = 1'b0;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        chk("rst_out_valid", 256'(out_if.valid), 256'(0));
        chk("rst_in_ready", 256'(in_if.ready), 256'(1));
        chk("rst_uop_count", 256'(uop_count), 256'(0));
        chk("rst_pair_err", 256'(pair_err), 256'(0));
        reset = 1'b1;

        // Single uop, rd=5, uuid=0x10.
        stim_q.delete();
        stim_q.push_back(mk_beat(32'h10, 1, 5));
        stim_q.push_back(mk_beat(32'h10, 1, 5));
        run(0, 50);
        chk("single_n", 256'(outs.size()), 256'(2));
        chk("single_rd0", 256'(outs[0].rd), 256'(5));
        chk("single_sop0", 256'({outs[0].sop, outs[0].eop}), 256'(2'b10));
        chk("single_rd1", 256'(outs[1].rd), 256'(6));
        chk("single_sop1", 256'({outs[1].sop, outs[1].eop}), 256'(2'b01));
        chk("single_gap", 256'(out_cyc[1] - out_cyc[0]), 256'(1));
        chk("single_cnt", 256'(uop_count), 256'(1));

        // Eight random uops back-to-back with out ready held high.
        do_reset();
        stim_q.delete();
        add_pairs(8);
        saved_q = stim_q;
        ready_low_seen = 1'b0;
        run(0, 100);
        chk("stream_n", 256'(outs.size()), 256'(16));
        chk("stream_bubbles", 256'(out_cyc[15] - out_cyc[0]), 256'(15));
        chk("stream_ready_low", 256'(ready_low_seen), 256'(0));
        chk("stream_cnt", 256'(uop_count), 256'(8));

        // Same uops with out ready toggling; ready must drop only when two beats are held.
        do_reset();
        stim_q = saved_q;
        ready_low_seen = 1'b0;
        run(1, 200);
        chk("toggle_n", 256'(outs.size()), 256'(16));
        chk("toggle_ready_low", 256'(ready_low_seen), 256'(1));
        chk("toggle_cnt", 256'(uop_count), 256'(8));

        // uuid mismatch on the second beat.
        do_reset();
        stim_q.delete();
        stim_q.push_back(mk_beat(32'h10, 2, 7));
        stim_q.push_back(mk_beat(32'h11, 2, 7));
        run(0, 50);
        repeat (3) cycle(f);
        chk("mismatch_n", 256'(outs.size()), 256'(2));
        chk("mismatch_err", 256'(pair_err), 256'(CHK));

        // rd at the top of the register space wraps to 0.
        do_reset();
        stim_q.delete();
        stim_q.push_back(mk_beat(32'h20, 0, (1 << NR_BITS) - 1));
        stim_q.push_back(mk_beat(32'h20, 0, (1 << NR_BITS) - 1));
        run(0, 50);
        cycle(f);
        chk("wrap_rd1", 256'(outs[1].rd), 256'(0));
        chk("wrap_err", 256'(pair_err), 256'(CHK));

        // Reset asserted mid-pair with a beat still buffered.
        do_reset();
        in_if.valid  = 1'b1;
        in_if.data   = mk_beat(32'h30, 1, 9);
        out_if.ready = 1'b0;
        cycle(f);
        chk("midrst_accept", 256'(f), 256'(1));
        in_if.valid = 1'b0;
        cycle(f);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", 256'(out_if.valid), 256'(0));
        chk("midrst_in_ready", 256'(in_if.ready), 256'(1));
        chk("midrst_uop_count", 256'(uop_count), 256'(0));
        chk("midrst_pair_err", 256'(pair_err), 256'(0));
        model_clear();
        out_if.ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        stim_q.delete();
        stim_q.push_back(mk_beat(32'h31, 3, 3));
        stim_q.push_back(mk_beat(32'h31, 3, 3));
        run(0, 50);
        chk("midrst_rd0", 256'(outs[0].rd), 256'(3));
        chk("midrst_sop0", 256'(outs[0].sop), 256'(1));
        chk("midrst_rd1", 256'(outs[1].rd), 256'(4));
        chk("midrst_cnt", 256'(uop_count), 256'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
